// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue
// -----------------------------------------------------------------------------
// Consumer end of the branch-prediction interface. IF pushes one prediction
// record per fetched instruction (PC, opcode, predicted direction, perceptron
// sum, predicted target). When the instruction reaches EX/MEM it resolves and
// pops the head record. The head is compared against the actual outcome, and
// the block produces a registered redirect (flush + refetch PC) and a
// registered training request for the perceptron predictor.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   push, push_*          enqueue one prediction record
//   full, empty           queue occupancy (combinational from count)
//   res_valid, res_*      resolving instruction; pops the head when non-empty
//   redirect, redirect_pc one-cycle flush pulse and refetch PC (PC holds)
//   train_en, train_*     one-cycle train pulse, PC and outcome (values hold)
//   tag_err, ovf, unf     sticky error flags, cleared only by rst
//
// Optional feature (macro BP_RESOLVE_STATS_EN)
//   stat_branches         saturating count of op_br resolves
//   stat_mispredicts      saturating count of op_br/op_jal redirects
//
// Handshake: push is a fire-and-forget valid; there is no ready. A push is
// accepted when the queue has room (or a pop frees a slot in the same cycle)
// and the cycle is on the correct path. A rejected push because of a full
// queue sets ovf. res_valid pops only when the queue is non-empty; otherwise
// it sets unf and has no other effect.
// -----------------------------------------------------------------------------
module bp_resolve_queue #(
  parameter int w_bits = 8,
  parameter int depth  = 4,
  parameter int theta  = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [31:0]       push_pc,
  input  logic [6:0]        push_opcode,
  input  logic              push_br_en,
  input  logic [w_bits-1:0] push_y_out,
  input  logic [31:0]       push_target,
  output logic              full,
  output logic              empty,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic              res_br_en,
  input  logic [31:0]       res_alu_out,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              train_en,
  output logic [31:0]       train_pc,
  output logic              train_taken,
  output logic              tag_err,
  output logic              ovf,
  output logic              unf
`ifdef BP_RESOLVE_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0]     depth_c = cw'(depth);
  localparam logic [w_bits-1:0] theta_w = w_bits'(theta);
  localparam logic [6:0] op_br  = 7'b1100011;
  localparam logic [6:0] op_jal = 7'b1101111;

  typedef struct packed {
    logic [31:0]       pc;
    logic [6:0]        opcode;
    logic              br_en;
    logic [w_bits-1:0] y_out;
    logic [31:0]       target;
  } entry_t;

  // Storage is not reset: an entry is only ever read while count covers it.
  entry_t          ent_q [depth];
  entry_t          ent_d [depth];
  logic [aw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw-1:0]   count_q, count_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            train_en_q, train_en_d;
  logic [31:0]     train_pc_q, train_pc_d;
  logic            train_taken_q, train_taken_d;
  logic            tag_err_q, tag_err_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0]     stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
`endif

  entry_t          head;
  logic            pop, push_ok, mispredict, do_train, y_small, flush;
  logic [w_bits-1:0] abs_y;
  logic [31:0]     target_calc;

  assign full  = (count_q == depth_c);
  assign empty = (count_q == '0);

  always_comb begin
    ent_d         = ent_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    redirect_pc_d = redirect_pc_q;
    train_pc_d    = train_pc_q;
    train_taken_d = train_taken_q;
    tag_err_d     = tag_err_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    mispredict    = 1'b0;
    do_train      = 1'b0;
    target_calc   = 32'd0;

    head = ent_q[rptr_q];
    pop  = res_valid && !empty;

    // Two's-complement magnitude; the most-negative value stays negative
    // and is therefore treated as large (never "small").
    abs_y   = head.y_out[w_bits-1] ? (~head.y_out + w_bits'(1)) : head.y_out;
    y_small = !abs_y[w_bits-1] && (abs_y <= theta_w);

    if (head.opcode == op_br) begin
      mispredict  = (head.br_en != res_br_en) ||
                    (res_br_en && (head.target != res_alu_out));
      target_calc = res_br_en ? res_alu_out : (head.pc + 32'd4);
      do_train    = mispredict || y_small;
    end else if (head.opcode == op_jal) begin
      mispredict  = (head.target != res_alu_out);
      target_calc = res_alu_out;
    end

    flush      = pop && mispredict;
    redirect_d = flush;
    train_en_d = pop && do_train;
    if (flush)      redirect_pc_d = target_calc;
    if (train_en_d) begin
      train_pc_d    = head.pc;
      train_taken_d = res_br_en;
    end

    // The cycle after a redirect still fetches wrong-path instructions.
    push_ok = push && !redirect_q && (!full || pop);

    if (flush) begin
      // Everything younger than the mispredicted head is wrong-path.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        ent_d[wptr_q] = '{pc: push_pc, opcode: push_opcode, br_en: push_br_en,
                          y_out: push_y_out, target: push_target};
        wptr_d = wptr_q + aw'(1);
      end
      if (pop) rptr_d = rptr_q + aw'(1);
      count_d = count_q + cw'(push_ok) - cw'(pop);
    end

    if (pop && (res_pc != head.pc))            tag_err_d = 1'b1;
    if (push && full && !pop && !redirect_q)   ovf_d     = 1'b1;
    if (res_valid && empty)                    unf_d     = 1'b1;

`ifdef BP_RESOLVE_STATS_EN
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (pop && (head.opcode == op_br) && (stat_br_q != 32'hFFFF_FFFF))
      stat_br_d = stat_br_q + 32'd1;
    if (flush && (stat_mp_q != 32'hFFFF_FFFF))
      stat_mp_d = stat_mp_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      train_en_q    <= 1'b0;
      train_pc_q    <= 32'd0;
      train_taken_q <= 1'b0;
      tag_err_q     <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
`ifdef BP_RESOLVE_STATS_EN
      stat_br_q     <= 32'd0;
      stat_mp_q     <= 32'd0;
`endif
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      train_en_q    <= train_en_d;
      train_pc_q    <= train_pc_d;
      train_taken_q <= train_taken_d;
      tag_err_q     <= tag_err_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
`ifdef BP_RESOLVE_STATS_EN
      stat_br_q     <= stat_br_d;
      stat_mp_q     <= stat_mp_d;
`endif
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign train_en    = train_en_q;
  assign train_pc    = train_pc_q;
  assign train_taken = train_taken_q;
  assign tag_err     = tag_err_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
`ifdef BP_RESOLVE_STATS_EN
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Testbench for bp_resolve_queue: per-cycle vector table (inputs applied one
// cycle, outputs expected after the following clock edge) plus hand-written
// reset sequences.
module tb_bp_resolve_queue;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [31:0] push_pc;
  logic [6:0]  push_opcode;
  logic        push_br_en;
  logic [7:0]  push_y_out;
  logic [31:0] push_target;
  logic        full, empty;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_br_en;
  logic [31:0] res_alu_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        train_en;
  logic [31:0] train_pc;
  logic        train_taken;
  logic        tag_err, ovf, unf;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  bp_resolve_queue #(.w_bits(8), .depth(4), .theta(37)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_pc(push_pc), .push_opcode(push_opcode),
    .push_br_en(push_br_en), .push_y_out(push_y_out), .push_target(push_target),
    .full(full), .empty(empty),
    .res_valid(res_valid), .res_pc(res_pc), .res_br_en(res_br_en),
    .res_alu_out(res_alu_out),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .train_en(train_en), .train_pc(train_pc), .train_taken(train_taken),
    .tag_err(tag_err), .ovf(ovf), .unf(unf)
`ifdef BP_RESOLVE_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] ppc;
    logic [6:0]  pop;
    logic        pbr;
    logic [7:0]  py;
    logic [31:0] ptgt;
    logic        rv;
    logic [31:0] rpc;
    logic        rbr;
    logic [31:0] ralu;
    logic        e_full, e_empty, e_redir;
    logic [31:0] e_rpc;
    logic        e_tr;
    logic [31:0] e_tpc;
    logic        e_tt, e_tag, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   total  = 0;
  int   passed = 0;

  // ---------------- table building ----------------
  task automatic clr();
    cur = '{push: 0, ppc: 0, pop: OP_IMM, pbr: 0, py: 0, ptgt: 0,
            rv: 0, rpc: 0, rbr: 0, ralu: 0,
            e_full: 0, e_empty: 0, e_redir: 0, e_rpc: 0, e_tr: 0, e_tpc: 0,
            e_tt: 0, e_tag: 0, e_ovf: 0, e_unf: 0};
  endtask

  task automatic ps(input logic [31:0] pc, input logic [6:0] op,
                    input logic br, input logic [7:0] y, input logic [31:0] tgt);
    cur.push = 1; cur.ppc = pc; cur.pop = op; cur.pbr = br; cur.py = y; cur.ptgt = tgt;
  endtask

  task automatic rs(input logic [31:0] pc, input logic br, input logic [31:0] alu);
    cur.rv = 1; cur.rpc = pc; cur.rbr = br; cur.ralu = alu;
  endtask

  task automatic ex(input logic f, input logic e, input logic r, input logic [31:0] rpc,
                    input logic t, input logic [31:0] tpc, input logic tt,
                    input logic tag, input logic ov, input logic un);
    cur.e_full = f; cur.e_empty = e; cur.e_redir = r; cur.e_rpc = rpc;
    cur.e_tr = t; cur.e_tpc = tpc; cur.e_tt = tt;
    cur.e_tag = tag; cur.e_ovf = ov; cur.e_unf = un;
    vecs.push_back(cur);
    clr();
  endtask

  // ---------------- driver ----------------
  task automatic apply(input vec_t v);
    push = v.push; push_pc = v.ppc; push_opcode = v.pop; push_br_en = v.pbr;
    push_y_out = v.py; push_target = v.ptgt;
    res_valid = v.rv; res_pc = v.rpc; res_br_en = v.rbr; res_alu_out = v.ralu;
  endtask

  task automatic idle();
    clr();
    apply(cur);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d.full", i),        full,        v.e_full);
    chk($sformatf("v%0d.empty", i),       empty,       v.e_empty);
    chk($sformatf("v%0d.redirect", i),    redirect,    v.e_redir);
    chk($sformatf("v%0d.redirect_pc", i), redirect_pc, v.e_rpc);
    chk($sformatf("v%0d.train_en", i),    train_en,    v.e_tr);
    chk($sformatf("v%0d.train_pc", i),    train_pc,    v.e_tpc);
    chk($sformatf("v%0d.train_taken", i), train_taken, v.e_tt);
    chk($sformatf("v%0d.tag_err", i),     tag_err,     v.e_tag);
    chk($sformatf("v%0d.ovf", i),         ovf,         v.e_ovf);
    chk($sformatf("v%0d.unf", i),         unf,         v.e_unf);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".full"},        full,        1'b0);
    chk({tag, ".empty"},       empty,       1'b1);
    chk({tag, ".redirect"},    redirect,    1'b0);
    chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, ".train_en"},    train_en,    1'b0);
    chk({tag, ".train_pc"},    train_pc,    32'd0);
    chk({tag, ".train_taken"}, train_taken, 1'b0);
    chk({tag, ".tag_err"},     tag_err,     1'b0);
    chk({tag, ".ovf"},         ovf,         1'b0);
    chk({tag, ".unf"},         unf,         1'b0);
  endtask

  initial begin
    // ---- vector table: ex(full,empty,redir,rpc,tr,tpc,tt,tag,ovf,unf) ----
    clr();
    // fill to full, overflow, push+pop while full, drain
    ps(32'h60, OP_IMM, 0, 0, 0);                       ex(0,0,0,0,0,0,0,0,0,0);
    ps(32'h64, OP_IMM, 0, 0, 0);                       ex(0,0,0,0,0,0,0,0,0,0);
    ps(32'h68, OP_IMM, 0, 0, 0);                       ex(0,0,0,0,0,0,0,0,0,0);
    ps(32'h6C, OP_IMM, 0, 0, 0);                       ex(1,0,0,0,0,0,0,0,0,0);
    ps(32'h99, OP_IMM, 0, 0, 0);                       ex(1,0,0,0,0,0,0,0,1,0);
    ps(32'h70, OP_IMM, 0, 0, 0); rs(32'h60, 0, 0);     ex(1,0,0,0,0,0,0,0,1,0);
    rs(32'h64, 0, 0);                                  ex(0,0,0,0,0,0,0,0,1,0);
    rs(32'h68, 0, 0);                                  ex(0,0,0,0,0,0,0,0,1,0);
    rs(32'h6C, 0, 0);                                  ex(0,0,0,0,0,0,0,0,1,0);
    rs(32'h70, 0, 0);                                  ex(0,1,0,0,0,0,0,0,1,0);
    // branch direction mispredict, small |y| (-16)
    ps(32'h100, OP_BR, 0, 8'hF0, 32'h104);             ex(0,0,0,0,0,0,0,0,1,0);
    rs(32'h100, 1, 32'h200);                           ex(0,1,1,32'h200,1,32'h100,1,0,1,0);
    clr();                                             ex(0,1,0,32'h200,0,32'h100,1,0,1,0);
    // correct, confident (80): nothing
    ps(32'h200, OP_BR, 1, 8'h50, 32'h300);             ex(0,0,0,32'h200,0,32'h100,1,0,1,0);
    rs(32'h200, 1, 32'h300);                           ex(0,1,0,32'h200,0,32'h100,1,0,1,0);
    // correct, low confidence (32): train only
    ps(32'h204, OP_BR, 1, 8'h20, 32'h300);             ex(0,0,0,32'h200,0,32'h100,1,0,1,0);
    rs(32'h204, 1, 32'h300);                           ex(0,1,0,32'h200,1,32'h204,1,0,1,0);
    clr();                                             ex(0,1,0,32'h200,0,32'h204,1,0,1,0);
    // jal target mispredict flushes younger entries and same-cycle push
    ps(32'h40, OP_JAL, 1, 0, 32'h44);                  ex(0,0,0,32'h200,0,32'h204,1,0,1,0);
    ps(32'h44, OP_IMM, 0, 0, 0);                       ex(0,0,0,32'h200,0,32'h204,1,0,1,0);
    ps(32'h48, OP_IMM, 0, 0, 0); rs(32'h40, 0, 32'h80);ex(0,1,1,32'h80,0,32'h204,1,0,1,0);
    ps(32'h4C, OP_IMM, 0, 0, 0);                       ex(0,1,0,32'h80,0,32'h204,1,0,1,0);
    // resolve on empty
    rs(32'h0, 0, 0);                                   ex(0,1,0,32'h80,0,32'h204,1,0,1,1);
    // tag mismatch
    ps(32'h500, OP_IMM, 0, 0, 0);                      ex(0,0,0,32'h80,0,32'h204,1,0,1,1);
    rs(32'h504, 0, 0);                                 ex(0,1,0,32'h80,0,32'h204,1,1,1,1);
    // predicted taken, actually not taken: refetch pc+4, train not-taken
    ps(32'h5F0, OP_BR, 1, 8'h80, 32'h600);             ex(0,0,0,32'h80,0,32'h204,1,1,1,1);
    rs(32'h5F0, 0, 32'h0);                             ex(0,1,1,32'h5F4,1,32'h5F0,0,1,1,1);
    clr();                                             ex(0,1,0,32'h5F4,0,32'h5F0,0,1,1,1);
    // correct with y=-128: magnitude is large, no train
    ps(32'h700, OP_BR, 1, 8'h80, 32'h710);             ex(0,0,0,32'h5F4,0,32'h5F0,0,1,1,1);
    rs(32'h700, 1, 32'h710);                           ex(0,1,0,32'h5F4,0,32'h5F0,0,1,1,1);

    // ---- reset ----
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end
    idle();

`ifdef BP_RESOLVE_STATS_EN
    // op_br resolves: 0x100, 0x200, 0x204, 0x5F0, 0x700; redirects: 0x100, 0x40, 0x5F0
    chk("stat_branches",    stat_branches,    32'd5);
    chk("stat_mispredicts", stat_mispredicts, 32'd3);
`endif

    // ---- reset mid-operation discards queue, pending pulse and stickies ----
    clr(); ps(32'h900, OP_BR, 0, 8'h00, 32'h904); apply(cur);
    @(posedge clk); #1;
    chk("mid.empty_before", empty, 1'b0);
    clr(); rs(32'h900, 1, 32'hA00); apply(cur);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    check_cleared("mid_rst");
    @(posedge clk); #1;
    chk("mid.redirect_after", redirect,    1'b0);
    chk("mid.train_after",    train_en,    1'b0);
    chk("mid.rpc_after",      redirect_pc, 32'd0);
`ifdef BP_RESOLVE_STATS_EN
    chk("mid.stat_branches",    stat_branches,    32'd0);
    chk("mid.stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
